// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: opcode decode plus memory wait, debounced IN, HALT and interrupt entry.
// Single-cycle ops commit in the cycle they are presented; LW/SW take 1+MEM_LATENCY cycles; IN stalls on Button.
module control_sequencer #(
  parameter int OPCODE_W    = 6,
  parameter int MEM_LATENCY = 1,
  parameter int DEBOUNCE    = 4,
  parameter int INT_ENABLE  = 1,
  parameter int HALT_WAKE   = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Button,
  input  logic                IntReq,
  output logic [2:0]          AluOp,
  output logic                RegDst,
  output logic                MemRead,
  output logic                MemtoReg,
  output logic                MemWrite,
  output logic                ALUSrc,
  output logic                RegWrite,
  output logic                PCFunct,
  output logic                BEQ,
  output logic                BNE,
  output logic                ControlJump,
  output logic                Halt,
  output logic                In,
  output logic                Out,
  output logic                JAL,
  output logic                Disp,
  output logic                savePC,
  output logic                savePCBuffer,
  output logic                setClock,
  output logic                getInterruption,
  output logic                EnableClock,
  output logic                IntSave,
  output logic                IntJump,
  output logic                IllegalOp,
  output logic [3:0]          State
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam int DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam bit MEM_MC = (MEM_LATENCY > 0);
  localparam bit INT_ON = (INT_ENABLE != 0);
  localparam bit WAKE_ON = (HALT_WAKE != 0) && (INT_ENABLE != 0);

  typedef enum logic [3:0] {
    BOOT       = 4'd0,
    RUN        = 4'd1,
    MEM_WAIT   = 4'd2,
    IN_WAIT    = 4'd3,
    IN_COMMIT  = 4'd4,
    IN_RELEASE = 4'd5,
    HALTED     = 4'd6,
    INT_SAVE   = 4'd7,
    INT_JUMP   = 4'd8
  } state_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       mem_read;
    logic       memto_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       pc_funct;
    logic       beq;
    logic       bne;
    logic       jump;
    logic       halt;
    logic       in_op;
    logic       out_op;
    logic       jal;
    logic       disp;
    logic       save_pc;
    logic       save_pcbuf;
    logic       set_clock;
    logic       get_int;
    logic       en_clk;
    logic       int_save;
    logic       int_jump;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [5:0] op, input logic legal);
    ctrl_t c;
    c          = '0;
    c.pc_funct = 1'b1;
    if (!legal) begin
      c.illegal = 1'b1;
    end else begin
      case (op)
        6'h00: begin c.reg_write = 1'b1; c.alu_op = 3'd2; end
        6'h23: begin
          c.reg_write = 1'b1; c.mem_read = 1'b1; c.memto_reg = 1'b1;
          c.alu_src   = 1'b1; c.reg_dst  = 1'b1;
        end
        6'h2B: begin
          c.mem_write = 1'b1; c.memto_reg = 1'b1; c.alu_src = 1'b1; c.reg_dst = 1'b1;
        end
        6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h2D: begin
          c.reg_write = 1'b1; c.alu_src = 1'b1; c.reg_dst = 1'b1;
          case (op)
            6'h09:   c.alu_op = 3'd1;
            6'h0C:   c.alu_op = 3'd3;
            6'h0D:   c.alu_op = 3'd4;
            6'h0A:   c.alu_op = 3'd5;
            6'h2D:   c.alu_op = 3'd6;
            default: c.alu_op = 3'd0;
          endcase
        end
        6'h04: begin c.beq = 1'b1; c.alu_op = 3'd1; end
        6'h05: begin c.bne = 1'b1; c.alu_op = 3'd1; end
        6'h1F: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.in_op = 1'b1; end
        6'h1E: c.out_op = 1'b1;
        6'h02: c.jump = 1'b1;
        6'h03: begin c.reg_write = 1'b1; c.jump = 1'b1; c.jal = 1'b1; end
        6'h3F: begin c.halt = 1'b1; c.pc_funct = 1'b0; end
        6'h3E: c.disp = 1'b1;
        6'h24: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.save_pc = 1'b1; end
        6'h34: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.save_pcbuf = 1'b1; end
        6'h01: c.set_clock = 1'b1;
        6'h06: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.get_int = 1'b1; end
        default: c.illegal = 1'b1;
      endcase
    end
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             mask_q, mask_d;
  logic             lw_q, lw_d;
  logic             pend_q, pend_d;

  ctrl_t ctl, dec, dec_mem, dec_in;
  logic  hi_zero;
  logic  int_ok;

  always_comb begin
    hi_zero = ((Opcode >> 6) == '0);
    dec     = decode(Opcode[5:0], hi_zero);
    dec_mem = decode(lw_q ? 6'h23 : 6'h2B, 1'b1);
    dec_in  = decode(6'h1F, 1'b1);
    int_ok  = INT_ON && IntReq && !mask_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    mask_d  = mask_q;
    lw_d    = lw_q;
    pend_d  = pend_q;
    ctl     = '0;

    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        ctl = dec;
        if (dec.halt) begin
          state_d = HALTED;
        end else if (MEM_MC && (dec.mem_read || dec.mem_write)) begin
          ctl.reg_write = 1'b0;
          ctl.mem_write = 1'b0;
          cnt_d         = CNT_W'(MEM_LATENCY);
          lw_d          = dec.mem_read;
          state_d       = MEM_WAIT;
        end else if (dec.in_op) begin
          ctl.reg_write = 1'b0;
          deb_d         = '0;
          state_d       = IN_WAIT;
        end else begin
          ctl.en_clk = 1'b1;
          if (dec.get_int) mask_d = 1'b0;
          if (int_ok) state_d = INT_SAVE;
        end
      end
      MEM_WAIT: begin
        ctl           = dec_mem;
        ctl.reg_write = 1'b0;
        ctl.mem_write = 1'b0;
        if (cnt_q == CNT_W'(1)) begin
          ctl.reg_write = lw_q;
          ctl.mem_write = !lw_q;
          ctl.en_clk    = 1'b1;
          state_d       = int_ok ? INT_SAVE : RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      IN_WAIT: begin
        ctl           = dec_in;
        ctl.reg_write = 1'b0;
        if (!Button) begin
          deb_d = '0;
        end else if (deb_q == DEB_W'(DEBOUNCE - 1)) begin
          deb_d   = '0;
          state_d = IN_COMMIT;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end
      IN_COMMIT: begin
        ctl        = dec_in;
        ctl.en_clk = 1'b1;
        pend_d     = int_ok;
        state_d    = IN_RELEASE;
      end
      // An interrupt taken at IN commit is deferred until the button is released.
      IN_RELEASE: begin
        if (!Button) begin
          state_d = pend_q ? INT_SAVE : RUN;
          pend_d  = 1'b0;
        end
      end
      HALTED: begin
        ctl.halt = 1'b1;
        if (WAKE_ON && IntReq) state_d = INT_SAVE;
      end
      INT_SAVE: begin
        ctl.int_save = 1'b1;
        state_d      = INT_JUMP;
      end
      INT_JUMP: begin
        ctl.int_jump = 1'b1;
        ctl.en_clk   = 1'b1;
        mask_d       = 1'b1;
        state_d      = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      deb_q   <= '0;
      mask_q  <= 1'b0;
      lw_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      mask_q  <= mask_d;
      lw_q    <= lw_d;
      pend_q  <= pend_d;
    end
  end

  assign AluOp           = ctl.alu_op;
  assign RegDst          = ctl.reg_dst;
  assign MemRead         = ctl.mem_read;
  assign MemtoReg        = ctl.memto_reg;
  assign MemWrite        = ctl.mem_write;
  assign ALUSrc          = ctl.alu_src;
  assign RegWrite        = ctl.reg_write;
  assign PCFunct         = ctl.pc_funct;
  assign BEQ             = ctl.beq;
  assign BNE             = ctl.bne;
  assign ControlJump     = ctl.jump;
  assign Halt            = ctl.halt;
  assign In              = ctl.in_op;
  assign Out             = ctl.out_op;
  assign JAL             = ctl.jal;
  assign Disp            = ctl.disp;
  assign savePC          = ctl.save_pc;
  assign savePCBuffer    = ctl.save_pcbuf;
  assign setClock        = ctl.set_clock;
  assign getInterruption = ctl.get_int;
  assign EnableClock     = ctl.en_clk;
  assign IntSave         = ctl.int_save;
  assign IntJump         = ctl.int_jump;
  assign IllegalOp       = ctl.illegal;
  assign State           = state_q;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Multi-cycle successor to the single-cycle opcode decoder in the processor control path. It decodes the same opcode map into the same datapath control signals, and adds a state machine for four things: a parametrised memory wait, a debounced IN handshake on Button, a latched HALT, and a two-cycle interrupt entry. EnableClock acts as the PC/pipeline advance enable. The datapath sees one instruction complete per cycle in which EnableClock=1.

Parameters:
OPCODE_W, 6, opcode width; bits above [5:0] must be zero or the opcode is illegal
MEM_LATENCY, 1, extra wait cycles for LW/SW (0 = single cycle)
DEBOUNCE, 4, consecutive cycles Button must be high to accept IN (>=1)
INT_ENABLE, 1, 1 = IntReq honoured
HALT_WAKE, 0, 1 = IntReq exits HALTED into interrupt entry

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
Opcode  in  OPCODE_W  current instruction opcode
Button  in  1  user input strobe for IN (synchronous to clock)
IntReq  in  1  level interrupt request
AluOp  out  3  ALU operation
RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, PCFunct, BEQ, BNE, ControlJump, Halt, In, Out, JAL, Disp, savePC, savePCBuffer, setClock, getInterruption  out  1 each  datapath controls
EnableClock  out  1  PC advance / instruction commit
IntSave  out  1  datapath latches next-PC into interrupt buffer
IntJump  out  1  PC loads interrupt vector
IllegalOp  out  1  unknown opcode this cycle
State  out  4  FSM state (debug)

Behaviour:
- Decode values (hex opcode; listed signals =1, all others 0). PCFunct=1 for every opcode except HALT.
  - 00 R: RegWrite, AluOp=2
  - 23 LW: RegWrite, MemRead, MemtoReg, ALUSrc, RegDst, AluOp=0
  - 2B SW: MemWrite, MemtoReg, ALUSrc, RegDst
  - 08/09/0C/0D/0A/2D ADDI/SUBI/ANDI/ORI/SLTI/XORI: RegWrite, ALUSrc, RegDst; AluOp = 0/1/3/4/5/6
  - 04 BEQ: BEQ, AluOp=1
  - 05 BNE: BNE, AluOp=1
  - 1F IN: RegWrite, RegDst, In
  - 1E OUT: Out
  - 02 J: ControlJump
  - 03 JAL: RegWrite, ControlJump, JAL
  - 3F HALT: Halt, PCFunct=0
  - 3E DISP: Disp
  - 24 PC: RegWrite, RegDst, savePC
  - 34 PCBUF: RegWrite, RegDst, savePCBuffer
  - 01 SETCLK: setClock
  - 06 GETINT: RegWrite, RegDst, getInterruption
- Other opcodes: NOP (PCFunct=1, EnableClock=1, all else 0) and IllegalOp=1 for that cycle. Decode is fully specified for every opcode, so no latches.
- State encoding: BOOT=0, RUN=1, MEM_WAIT=2, IN_WAIT=3, IN_COMMIT=4, IN_RELEASE=5, HALTED=6, INT_SAVE=7, INT_JUMP=8.
- Reset (async, reset_n=0):
  - state -> BOOT; counters and in-service mask cleared.
  - All outputs 0 while in reset and during BOOT, including EnableClock.
  - BOOT -> RUN after one cycle.
- RUN, single-cycle ops: decoded controls are driven combinationally from Opcode; EnableClock=1.
- LW/SW with MEM_LATENCY>0:
  - RUN cycle: decoded controls, but RegWrite=MemWrite=0 and EnableClock=0; counter loads MEM_LATENCY; go to MEM_WAIT.
  - MEM_WAIT: controls held; counter decrements. When the counter reaches 1: RegWrite (LW) or MemWrite (SW) =1 and EnableClock=1, then go to RUN.
  - Total latency is 1+MEM_LATENCY cycles, and the write strobe is exactly one cycle.
- IN:
  - RUN cycle: go to IN_WAIT with In=1, RegWrite=0, EnableClock=0.
  - IN_WAIT: debounce counter increments while Button=1 and clears on Button=0. At DEBOUNCE consecutive highs, go to IN_COMMIT.
  - IN_COMMIT (1 cycle): In=1, RegWrite=1, RegDst=1, EnableClock=1; then go to IN_RELEASE.
  - IN_RELEASE: all outputs 0, EnableClock=0, until Button=0; then go to RUN. One press completes exactly one IN.
- HALT: RUN cycle drives Halt=1, EnableClock=0, then goes to HALTED.
  - HALTED holds Halt=1 and EnableClock=0 with all else 0.
  - Exit by reset only; or, if HALT_WAKE=1 and INT_ENABLE=1, by IntReq=1 -> INT_SAVE.
- Interrupt:
  - Sampled on any commit cycle (EnableClock=1 in RUN, MEM_WAIT or IN_COMMIT) when INT_ENABLE=1, IntReq=1 and the mask is clear.
  - The current instruction commits normally; next state is INT_SAVE, overriding RUN.
  - INT_SAVE: IntSave=1, EnableClock=0, all else 0.
  - INT_JUMP: IntJump=1, EnableClock=1, sets the mask; then go to RUN.
  - Mask clears when GETINT commits. IntReq held high while masked is ignored.
  - A HALT opcode in RUN takes priority over interrupt sampling.
- Opcode changes during MEM_WAIT, IN_* or HALTED states are ignored. Controls are taken from the opcode latched on entry.

Test Plan:
- reset_n low mid-MEM_WAIT -> State=0 immediately and all outputs 0; one cycle after release State=1.
- Opcode 08 in RUN -> RegWrite=ALUSrc=RegDst=PCFunct=EnableClock=1, AluOp=0, IllegalOp=0. Opcode 3A -> IllegalOp=1, EnableClock=1, RegWrite=0.
- MEM_LATENCY=2, LW -> EnableClock low for 2 cycles then high on the 3rd; RegWrite high only on the 3rd; MemRead high for all 3.
- IN with DEBOUNCE=4, Button 1,1,0,1,1,1,1 -> IN_COMMIT on the cycle after the 4th consecutive high; one RegWrite pulse; a second IN waits until Button drops.
- R-type with IntReq=1 -> instruction commits, then IntSave for 1 cycle, then IntJump with EnableClock=1. A second IntReq is ignored until GETINT commits.
- HALT_WAKE=1: HALT -> Halt held 10 cycles; IntReq -> INT_SAVE, INT_JUMP, RUN. With HALT_WAKE=0, IntReq has no effect.
